// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: state encoding, grant
// identifiers and the default block fill length.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam int BLOCK_WORDS_DEF = 8;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// Saturating beat counter: counts inc pulses up to limit, clears on clr.
module beat_counter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] count_r;

    // Count accepted beats; clear takes precedence, saturate at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && !at_limit) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign at_limit = (count_r >= limit);

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter between the I-cache and D-cache fill FSMs, with
// zero-latency D-cache write-through stores while no fill owns the memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int D_PRIORITY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_busy,
    input  logic        i_read_req,
    input  logic [15:0] i_addr,
    input  logic        d_busy,
    input  logic        d_read_req,
    input  logic [15:0] d_addr,
    input  logic        d_wrt,
    input  logic [15:0] d_wdata,
    input  logic        mem_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        i_pause,
    output logic        d_pause,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic        overrun_err
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(BLOCK_WORDS);

    arb_state_e state_r;
    logic       last_grant_r;
    logic       overrun_r;

    logic idle_s, fill_i_s, fill_d_s, fill_s;
    logic issue_full_s, ret_full_s;
    logic req_s, issue_inc_s, ret_inc_s, release_s, err_s;

    assign idle_s   = (state_r == IDLE);
    assign fill_i_s = (state_r == FILL_I);
    assign fill_d_s = (state_r == FILL_D);
    assign fill_s   = fill_i_s | fill_d_s;

    // Read request of whichever side currently owns the memory.
    assign req_s       = (fill_i_s & i_read_req) | (fill_d_s & d_read_req);
    assign issue_inc_s = req_s & ~issue_full_s;
    assign ret_inc_s   = fill_s & mem_data_valid & ~ret_full_s;
    assign release_s   = (fill_i_s & ~i_busy) | (fill_d_s & ~d_busy);

    // Overrun read, stray/excess return beat, or short fill.
    assign err_s = (req_s & issue_full_s)
                 | (mem_data_valid & (idle_s | (fill_s & ret_full_s)))
                 | (release_s & ~ret_full_s);

    beat_counter u_issue_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (release_s),
        .inc      (issue_inc_s),
        .limit    (LIMIT_C),
        .at_limit (issue_full_s)
    );

    beat_counter u_ret_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (release_s),
        .inc      (ret_inc_s),
        .limit    (LIMIT_C),
        .at_limit (ret_full_s)
    );

    // Ownership FSM: arbitrate in IDLE, hold a fill until its busy drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_I;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= overrun_r | err_s;
            case (state_r)
                IDLE: begin
                    if (d_busy && !i_busy) begin
                        state_r      <= FILL_D;
                        last_grant_r <= GRANT_D;
                    end else if (i_busy && !d_busy) begin
                        state_r      <= FILL_I;
                        last_grant_r <= GRANT_I;
                    end else if (i_busy && d_busy) begin
                        if ((D_PRIORITY == 1) || (last_grant_r == GRANT_I)) begin
                            state_r      <= FILL_D;
                            last_grant_r <= GRANT_D;
                        end else begin
                            state_r      <= FILL_I;
                            last_grant_r <= GRANT_I;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FILL_I: begin
                    if (!i_busy) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= FILL_I;
                    end
                end
                FILL_D: begin
                    if (!d_busy) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= FILL_D;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Memory port drive: stores in IDLE, owner's reads during a fill.
    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        case (state_r)
            IDLE: begin
                if (d_wrt) begin
                    mem_enable = 1'b1;
                    mem_wr     = 1'b1;
                    mem_addr   = d_addr;
                    mem_wdata  = d_wdata;
                end else begin
                    mem_enable = 1'b0;
                end
            end
            FILL_I: begin
                mem_enable = i_read_req & ~issue_full_s;
                mem_addr   = i_addr;
            end
            FILL_D: begin
                mem_enable = d_read_req & ~issue_full_s;
                mem_addr   = d_addr;
            end
            default: begin
                mem_enable = 1'b0;
            end
        endcase
        if (rst) begin
            mem_enable = 1'b0;
            mem_wr     = 1'b0;
            mem_addr   = 16'h0000;
            mem_wdata  = 16'h0000;
        end else begin
            mem_enable = mem_enable;
        end
    end

    // Pauses and return-beat steering; a return is dropped once the block is full.
    always_comb begin
        i_pause      = i_busy & ~fill_i_s;
        d_pause      = (d_busy & ~fill_d_s) | (d_wrt & fill_i_s);
        i_data_valid = mem_data_valid & fill_i_s & ~ret_full_s;
        d_data_valid = mem_data_valid & fill_d_s & ~ret_full_s;
        overrun_err  = overrun_r;
        if (rst) begin
            i_pause      = 1'b0;
            d_pause      = 1'b0;
            i_data_valid = 1'b0;
            d_data_valid = 1'b0;
            overrun_err  = 1'b0;
        end else begin
            i_pause = i_pause;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: D-priority instance plus a round-robin
// instance sharing the same stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_busy, i_read_req, d_busy, d_read_req, d_wrt, mem_data_valid;
    logic [15:0] i_addr, d_addr, d_wdata;

    logic        mem_enable, mem_wr, i_pause, d_pause, i_data_valid, d_data_valid, overrun_err;
    logic [15:0] mem_addr, mem_wdata;
    logic        rr_mem_enable, rr_mem_wr, rr_i_pause, rr_d_pause;
    logic        rr_i_data_valid, rr_d_data_valid, rr_overrun_err;
    logic [15:0] rr_mem_addr, rr_mem_wdata;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.BLOCK_WORDS(8), .D_PRIORITY(1)) dut (
        .clk(clk), .rst(rst),
        .i_busy(i_busy), .i_read_req(i_read_req), .i_addr(i_addr),
        .d_busy(d_busy), .d_read_req(d_read_req), .d_addr(d_addr),
        .d_wrt(d_wrt), .d_wdata(d_wdata), .mem_data_valid(mem_data_valid),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .i_pause(i_pause), .d_pause(d_pause),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .overrun_err(overrun_err)
    );

    mem_arbiter #(.BLOCK_WORDS(8), .D_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .i_busy(i_busy), .i_read_req(i_read_req), .i_addr(i_addr),
        .d_busy(d_busy), .d_read_req(d_read_req), .d_addr(d_addr),
        .d_wrt(d_wrt), .d_wdata(d_wdata), .mem_data_valid(mem_data_valid),
        .mem_enable(rr_mem_enable), .mem_wr(rr_mem_wr), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .i_pause(rr_i_pause), .d_pause(rr_d_pause),
        .i_data_valid(rr_i_data_valid), .d_data_valid(rr_d_data_valid),
        .overrun_err(rr_overrun_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_busy = 1'b0; i_read_req = 1'b0; i_addr = 16'h0000;
        d_busy = 1'b0; d_read_req = 1'b0; d_addr = 16'h0000;
        d_wrt = 1'b0; d_wdata = 16'h0000; mem_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        d_wrt = 1'b1; d_addr = 16'h1111; d_wdata = 16'h2222; i_busy = 1'b1; d_busy = 1'b1;
        #3;
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_pauses", {30'd0, i_pause, d_pause}, 32'd0);
        check("rst_overrun", 32'(overrun_err), 32'd0);
        step();
        do_reset();

        // I-miss alone
        i_busy = 1'b1; i_read_req = 1'b1; i_addr = 16'h1230;
        sample();
        check("imiss_idle_pause", 32'(i_pause), 32'd1);
        check("imiss_idle_noread", 32'(mem_enable), 32'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            i_addr = 16'h1230 + 16'(2 * k);
            mem_data_valid = 1'b1;
            sample();
            check("imiss_enable", 32'(mem_enable), 32'd1);
            check("imiss_addr", 32'(mem_addr), 32'(16'h1230 + 16'(2 * k)));
            check("imiss_valid", {30'd0, i_data_valid, d_data_valid}, 32'd2);
            check("imiss_pause", 32'(i_pause), 32'd0);
            step();
        end
        i_read_req = 1'b0; mem_data_valid = 1'b0; i_busy = 1'b0;
        step();
        sample();
        check("imiss_back_idle", {29'd0, mem_enable, i_pause, d_pause}, 32'd0);
        check("imiss_no_err", 32'(overrun_err), 32'd0);

        // Simultaneous misses: D wins under D priority, I request is masked
        step();
        i_busy = 1'b1; i_read_req = 1'b1; i_addr = 16'h2000;
        d_busy = 1'b1; d_read_req = 1'b1; d_addr = 16'h3000;
        step();
        for (int k = 0; k < 8; k++) begin
            mem_data_valid = 1'b1;
            sample();
            check("sim_d_addr", 32'(mem_addr), 32'h3000);
            check("sim_pauses", {30'd0, i_pause, d_pause}, 32'd2);
            check("sim_steer", {30'd0, i_data_valid, d_data_valid}, 32'd1);
            step();
        end
        mem_data_valid = 1'b0;
        sample();
        check("ovr_9th_masked", 32'(mem_enable), 32'd0);
        check("ovr_not_yet", 32'(overrun_err), 32'd0);
        step();
        sample();
        check("ovr_set", 32'(overrun_err), 32'd1);
        d_busy = 1'b0; d_read_req = 1'b0;
        step();
        sample();
        check("sim_idle_gap", {30'd0, i_pause, d_pause}, 32'd2);
        check("sim_idle_addr", 32'(mem_enable), 32'd0);
        step();
        sample();
        check("sim_then_fill_i", {30'd0, i_pause, d_pause}, 32'd0);
        check("sim_fill_i_addr", 32'(mem_addr), 32'h2000);
        check("ovr_sticky", 32'(overrun_err), 32'd1);
        i_busy = 1'b0; i_read_req = 1'b0;
        step();
        do_reset();
        check("reset_clears_err", 32'(overrun_err), 32'd0);

        // Store during I-fill is stalled, then issued in the IDLE cycle
        i_busy = 1'b1;
        step();
        d_wrt = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        sample();
        check("store_stall_pause", 32'(d_pause), 32'd1);
        check("store_stall_nowr", {30'd0, mem_enable, mem_wr}, 32'd0);
        i_busy = 1'b0;
        step();
        sample();
        check("store_issue_ctl", {30'd0, mem_enable, mem_wr}, 32'd3);
        check("store_issue_addr", 32'(mem_addr), 32'h0040);
        check("store_issue_data", 32'(mem_wdata), 32'hBEEF);
        check("store_no_pause", 32'(d_pause), 32'd0);
        d_wrt = 1'b0;
        step();
        sample();
        check("short_fill_err", 32'(overrun_err), 32'd1);
        do_reset();

        // Stray return beat in IDLE
        mem_data_valid = 1'b1;
        sample();
        check("stray_not_fwd", {30'd0, i_data_valid, d_data_valid}, 32'd0);
        step();
        mem_data_valid = 1'b0;
        sample();
        check("stray_err", 32'(overrun_err), 32'd1);
        do_reset();

        // Reset mid-fill at ret_cnt = 3, then a clean full regrant
        d_busy = 1'b1; d_read_req = 1'b1; d_addr = 16'h5000;
        step();
        mem_data_valid = 1'b1;
        step(); step(); step();
        rst = 1'b1;
        #1;
        check("midrst_outputs", {27'd0, mem_enable, i_pause, d_pause, i_data_valid, d_data_valid}, 32'd0);
        sample();
        rst = 1'b0;
        mem_data_valid = 1'b0;
        #1;
        check("midrst_idle_pause", 32'(d_pause), 32'd1);
        step();
        for (int k = 0; k < 8; k++) begin
            mem_data_valid = 1'b1;
            sample();
            check("regrant_valid", 32'(d_data_valid), 32'd1);
            check("regrant_enable", 32'(mem_enable), 32'd1);
            step();
        end
        mem_data_valid = 1'b0; d_busy = 1'b0; d_read_req = 1'b0;
        step();
        sample();
        check("regrant_no_err", 32'(overrun_err), 32'd0);
        do_reset();

        // Round-robin: last grant D, both busy -> I first on the RR instance
        d_busy = 1'b1;
        step();
        d_busy = 1'b0;
        step();
        i_busy = 1'b1; d_busy = 1'b1;
        step();
        sample();
        check("rr_grant_i", {30'd0, rr_i_pause, rr_d_pause}, 32'd1);
        check("prio_grant_d", {30'd0, i_pause, d_pause}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
